// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_sequencer
// Purpose  : Upstream feeder for the processor control unit. Owns the program
//            counter and reads instructions and immediates from a
//            synchronous-read program memory. Each instruction word goes out
//            on din_o with a one-cycle run_o pulse. The sequencer then waits
//            for done_i and advances the PC by 1, or by 2 when nextmem_i
//            reports that the immediate word was consumed.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W    program memory address / PC width
//   PROG_LEN  number of valid program words; fetch halts at next PC >= PROG_LEN
//   TIMEOUT   maximum EXEC cycles allowed before the watchdog trips (>= 1)
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        level; launches from PC=0 when idle or halted
//   mem_addr_o     program memory read address
//   mem_data_i     memory read data, valid one cycle after mem_addr_o
//   din_o          word presented to the control unit
//   run_o          one-cycle pulse: control unit loads din_o into IR
//   done_i         control unit has completed the instruction
//   nextmem_i      immediate at PC+1 was consumed (sampled with done_i)
//   pc_o           current instruction address
//   busy_o         high in FETCH, ISSUE and EXEC
//   halted_o       high in HALT
//   timeout_o      sticky watchdog flag, cleared by a launch or by reset
//   instr_count_o  accepted-instruction counter, saturating
//                  (present only with FETCH_INSTR_COUNT_EN)
// Optional feature macro: FETCH_INSTR_COUNT_EN
// ============================================================================
module instr_fetch_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_data_i,
  output logic [15:0]       din_o,
  output logic              run_o,
  input  logic              done_i,
  input  logic              nextmem_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              timeout_o
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [15:0]       instr_count_o
`endif
);

  localparam int                WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   TIMEOUT_W  = WD_W'(TIMEOUT);
  localparam logic [ADDR_W:0]   PROG_LEN_W = (ADDR_W + 1)'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WD_W-1:0]   wd_q;
  logic              run_q;
  logic              din_en_q;
  logic              busy_q;
  logic              halted_q;
  logic              timeout_q;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0]       instr_cnt_q;
`endif

  // Next-state datapath values
  logic [ADDR_W:0]   next_pc_d;   // one bit wider so the end-of-program test never wraps
  logic [ADDR_W-1:0] pc_inc_d;    // PC+1 prefetch address, wraps at the top of memory
  logic [WD_W-1:0]   wd_d;
  logic              launch_d;

  always_comb begin
    next_pc_d = {1'b0, pc_q} + (ADDR_W + 1)'(1) + {{ADDR_W{1'b0}}, nextmem_i};
    pc_inc_d  = pc_q + ADDR_W'(1);
    wd_d      = wd_q + WD_W'(1);
    launch_d  = start_i && ((state_q == S_IDLE) || (state_q == S_HALT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      wd_q        <= '0;
      run_q       <= 1'b0;
      din_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
      instr_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (launch_d) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
            instr_cnt_q <= '0;
`endif
          end else begin
            // Keep the memory pointed at the PC while parked
            mem_addr_q <= pc_q;
          end
        end

        S_FETCH: begin
          // The instruction word is captured by memory on this edge, so the
          // address can move on to the immediate slot right away.
          state_q    <= S_ISSUE;
          run_q      <= 1'b1;
          din_en_q   <= 1'b1;
          mem_addr_q <= pc_inc_d;
        end

        S_ISSUE: begin
          state_q <= S_EXEC;
          run_q   <= 1'b0;
          wd_q    <= '0;
        end

        S_EXEC: begin
          if (done_i) begin
            // Done has priority over a watchdog expiry in the same cycle
            pc_q       <= next_pc_d[ADDR_W-1:0];
            mem_addr_q <= next_pc_d[ADDR_W-1:0];
            din_en_q   <= 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
            if (instr_cnt_q != 16'hFFFF) begin
              instr_cnt_q <= instr_cnt_q + 16'd1;
            end
`endif
            if (next_pc_d >= PROG_LEN_W) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
            end
          end else if (wd_d == TIMEOUT_W) begin
            state_q    <= S_HALT;
            busy_q     <= 1'b0;
            halted_q   <= 1'b1;
            timeout_q  <= 1'b1;
            din_en_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else begin
            wd_q <= wd_d;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          run_q    <= 1'b0;
          din_en_q <= 1'b0;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory data is valid only in the cycle after the address, so din_o
  // forwards it directly; the gate is a register, so reset blanks din_o at once.
  assign din_o      = din_en_q ? mem_data_i : 16'h0000;
  assign mem_addr_o = mem_addr_q;
  assign run_o      = run_q;
  assign pc_o       = pc_q;
  assign busy_o     = busy_q;
  assign halted_o   = halted_q;
  assign timeout_o  = timeout_q;
`ifdef FETCH_INSTR_COUNT_EN
  assign instr_count_o = instr_cnt_q;
`endif

endmodule
`default_nettype wire
